// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer: FSM state encoding, the
// sequential PC increment and the default address/instruction widths.
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam int PC_STEP = 4;
  localparam int DEF_AW  = 20;
  localparam int DEF_IW  = 20;

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC arithmetic for the fetch sequencer.
//   pc     : current fetch PC
//   br_pc  : PC of the resolving branch
//   ext    : sign-extended word offset (20 bits)
//   taken  : branch taken this cycle
//   seq_pc : pc + 4 (mod 2^AW)
//   target : br_pc + 4 + (ext << 2) when taken, otherwise seq_pc, so it can
//            serve directly as "the PC to load" whenever the PC advances
// ---------------------------------------------------------------------------
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] br_pc,
  input  logic [19:0]   ext,
  input  logic          taken,
  output logic [AW-1:0] seq_pc,
  output logic [AW-1:0] target
);

  logic [AW-1:0] ext_sx;
  logic [AW-1:0] br_target;

  // Bring the offset to AW bits; wider PCs need the sign replicated.
  generate
    if (AW > 20) begin : g_ext_wide
      assign ext_sx = {{(AW-20){ext[19]}}, ext};
    end else begin : g_ext_narrow
      assign ext_sx = ext[AW-1:0];
    end
  endgenerate

  // All sums are AW bits wide, so overflow wraps modulo 2^AW.
  assign seq_pc    = pc + AW'(PC_STEP);
  assign br_target = br_pc + AW'(PC_STEP) + {ext_sx[AW-3:0], 2'b00};
  assign target    = taken ? br_target : seq_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Clocked, stallable PC/fetch sequencer between instruction memory and decode.
//   clk, rst_n           : clock, asynchronous active-low reset
//   en                   : fetch enable (0 = finish current fetch, then idle)
//   mem_req/mem_addr     : request to instruction memory (held until mem_gnt)
//   mem_gnt              : memory accepted the request
//   mem_rvalid/mem_rdata : one response per granted request
//   ins_valid/ins/ins_pc : fetched instruction for decode, held until ins_ready
//   branch/zero/br_pc/ext: branch resolution; taken = branch & zero
//   redirect             : one-cycle pulse after a taken branch is applied
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          AW       = DEF_AW,
  parameter int          IW       = DEF_IW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [IW-1:0] mem_rdata,
  output logic          ins_valid,
  output logic [IW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready,
  input  logic          branch,
  input  logic          zero,
  input  logic [AW-1:0] br_pc,
  input  logic [19:0]   ext,
  output logic          redirect
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          ins_valid_q, ins_valid_d;
  logic [IW-1:0] ins_q, ins_d;
  logic [AW-1:0] ins_pc_q, ins_pc_d;
  logic          redirect_q, redirect_d;

  logic          taken;
  logic          accept;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] target;

  assign taken = branch & zero;

  pc_next_calc #(.AW(AW)) u_pc_next_calc (
    .pc     (pc_q),
    .br_pc  (br_pc),
    .ext    (ext),
    .taken  (taken),
    .seq_pc (seq_pc),
    .target (target)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    ins_valid_d = ins_valid_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_gnt) state_d = ST_WAIT;
        // The request cannot be withdrawn; its response will be discarded.
        if (taken) drop_d = 1'b1;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          // A redirect arriving with the response also kills that response.
          if (drop_q || taken) begin
            drop_d  = 1'b0;
            state_d = en ? ST_REQ : ST_IDLE;
          end else begin
            ins_d       = mem_rdata;
            ins_pc_d    = pc_q;
            ins_valid_d = 1'b1;
            accept      = 1'b1;
            state_d     = ST_HOLD;
          end
        end else if (taken) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // Redirect and consumption both retire the held instruction.
        if (taken || ins_ready) begin
          ins_valid_d = 1'b0;
          state_d     = en ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (taken)       pc_d = target;
    else if (accept) pc_d = seq_pc;
    else             pc_d = pc_q;

    // Latch the address only on entry to REQ so it stays put until granted,
    // even if a redirect moves the PC meanwhile.
    mem_req_d  = (state_d == ST_REQ);
    mem_addr_d = (state_d == ST_REQ && state_q != ST_REQ) ? pc_d : mem_addr_q;
    redirect_d = taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_PC;
      ins_valid_q <= 1'b0;
      ins_q       <= '0;
      ins_pc_q    <= '0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ins_valid_q <= ins_valid_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      redirect_q  <= redirect_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ins_valid = ins_valid_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign redirect  = redirect_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed stimulus with a scoreboard: expected request addresses and
// expected instruction/PC pairs are queued by the stimulus; a monitor pops
// and compares on every memory grant and every decode handshake.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int AW = 20;
  localparam int IW = 20;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  logic          ins_valid;
  logic [IW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;
  logic          branch;
  logic          zero;
  logic [AW-1:0] br_pc;
  logic [19:0]   ext;
  logic          redirect;

  logic gnt_en;
  int   lat;
  int   checks;
  int   errors;
  int   ins_seen;
  int   ins_pushed;

  logic [AW-1:0]    exp_addr_q[$];
  logic [IW+AW-1:0] exp_ins_q[$];

  fetch_sequencer #(.AW(AW), .IW(IW), .RESET_PC(20'h00000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ins_valid  (ins_valid),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_ready  (ins_ready),
    .branch     (branch),
    .zero       (zero),
    .br_pc      (br_pc),
    .ext        (ext),
    .redirect   (redirect)
  );

  assign mem_gnt = mem_req & gnt_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 20'hA5C3F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: one response per grant, lat idle cycles in between.
  initial begin : mem_model
    logic          pend;
    logic [AW-1:0] paddr;
    int            cnt;
    pend       = 1'b0;
    paddr      = '0;
    cnt        = 0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend && cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(paddr);
          pend       = 1'b0;
        end else if (pend) begin
          cnt--;
        end
        if (mem_req && mem_gnt) begin
          pend  = 1'b1;
          paddr = mem_addr;
          cnt   = lat;
        end
      end
    end
  end

  initial begin : monitor
    logic [AW-1:0]    ea;
    logic [IW+AW-1:0] ei;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req && mem_gnt) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr 0x%0h, none expected", mem_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(ea));
          end
        end
        if (ins_valid && ins_ready) begin
          if (exp_ins_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ins: got ins 0x%0h pc 0x%0h, none expected", ins, ins_pc);
          end else begin
            ei = exp_ins_q.pop_front();
            chk("ins", 32'(ins), 32'(ei[IW+AW-1:AW]));
            chk("ins_pc", 32'(ins_pc), 32'(ei[AW-1:0]));
          end
          ins_seen++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_fetch(input logic [AW-1:0] a);
    exp_addr_q.push_back(a);
    exp_ins_q.push_back({mem_word(a), a});
    ins_pushed++;
  endtask

  task automatic wait_seen(input int n);
    for (int i = 0; i < 80; i++) begin
      if (ins_seen >= n) break;
      tick();
    end
    if (ins_seen < n) fail_now("wait_ins_handshake");
  endtask

  task automatic wait_ins_valid();
    for (int i = 0; i < 40; i++) begin
      if (ins_valid) break;
      tick();
    end
    if (!ins_valid) fail_now("wait_ins_valid");
  endtask

  // From IDLE: fetch exactly one instruction, optionally withholding gnt.
  task automatic fetch_single(input logic [AW-1:0] a, input int gd);
    exp_fetch(a);
    gnt_en = (gd == 0);
    en     = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < gd; i++) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("req_addr_stable", 32'(mem_addr), 32'(a));
      tick();
    end
    gnt_en = 1'b1;
    wait_seen(ins_pushed);
    tick();
  endtask

  task automatic do_branch(input logic [AW-1:0] bpc, input logic [19:0] e, input logic z);
    br_pc  = bpc;
    ext    = e;
    branch = 1'b1;
    zero   = z;
    tick();
    branch = 1'b0;
    zero   = 1'b0;
    chk("redirect_pulse", 32'(redirect), 32'(z));
    tick();
    chk("redirect_end", 32'(redirect), 32'd0);
  endtask

  initial begin : stimulus
    checks     = 0;
    errors     = 0;
    ins_seen   = 0;
    ins_pushed = 0;
    rst_n      = 1'b0;
    en         = 1'b0;
    ins_ready  = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    br_pc      = '0;
    ext        = '0;
    gnt_en     = 1'b1;
    lat        = 1;

    repeat (2) tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h00000);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", 32'(ins), 32'd0);
    chk("rst_ins_pc", 32'(ins_pc), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    rst_n     = 1'b1;
    ins_ready = 1'b1;
    tick();

    // Sequential fetch; en drops during the third fetch.
    exp_fetch(20'h00000);
    exp_fetch(20'h00004);
    exp_fetch(20'h00008);
    en = 1'b1;
    wait_seen(2);
    en = 1'b0;
    wait_seen(3);
    repeat (2) tick();
    chk("idle_after_en_low", 32'(mem_req), 32'd0);

    // Backpressure in HOLD.
    ins_ready = 1'b0;
    exp_fetch(20'h0000C);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_ins_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(ins_valid), 32'd1);
      chk("hold_ins", 32'(ins), 32'(mem_word(20'h0000C)));
      chk("hold_pc", 32'(ins_pc), 32'h0000C);
      chk("hold_no_req", 32'(mem_req), 32'd0);
      tick();
    end
    ins_ready = 1'b1;
    wait_seen(ins_pushed);
    tick();

    // Next fetch continues at ins_pc+4 with gnt withheld for 3 cycles.
    fetch_single(20'h00010, 3);

    // Branch arithmetic, applied while idle.
    do_branch(20'h00008, 20'h00003, 1'b1);
    fetch_single(20'h00018, 0);
    do_branch(20'h00020, 20'hFFFFE, 1'b1);
    fetch_single(20'h0001C, 0);
    do_branch(20'hFFFFC, 20'h00000, 1'b1);
    fetch_single(20'h00000, 0);
    do_branch(20'h00100, 20'h00040, 1'b0);
    fetch_single(20'h00004, 0);

    // Redirect during WAIT: old response is dropped, refetch at target.
    lat = 3;
    exp_addr_q.push_back(20'h00008);
    exp_fetch(20'h00048);
    en = 1'b1;
    tick();
    tick();
    do_branch(20'h00040, 20'h00001, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (mem_req) break;
      tick();
    end
    en = 1'b0;
    chk("wait_redirect_addr", 32'(mem_addr), 32'h00048);
    wait_seen(ins_pushed);
    tick();
    lat = 1;

    // Redirect coincident with ins_ready in HOLD.
    ins_ready = 1'b0;
    exp_fetch(20'h0004C);
    exp_fetch(20'h00144);
    en = 1'b1;
    tick();
    wait_ins_valid();
    ins_ready = 1'b1;
    br_pc     = 20'h00100;
    ext       = 20'h00010;
    branch    = 1'b1;
    zero      = 1'b1;
    tick();
    branch = 1'b0;
    zero   = 1'b0;
    en     = 1'b0;
    chk("hold_redir_pulse", 32'(redirect), 32'd1);
    chk("hold_redir_valid", 32'(ins_valid), 32'd0);
    chk("hold_redir_req", 32'(mem_req), 32'd1);
    chk("hold_redir_addr", 32'(mem_addr), 32'h00144);
    wait_seen(ins_pushed);
    tick();

    // Asynchronous reset mid-WAIT.
    lat = 5;
    exp_addr_q.push_back(20'h00148);
    en = 1'b1;
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'h00000);
    chk("arst_ins_valid", 32'(ins_valid), 32'd0);
    chk("arst_ins", 32'(ins), 32'd0);
    chk("arst_ins_pc", 32'(ins_pc), 32'd0);
    chk("arst_redirect", 32'(redirect), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lat   = 1;
    tick();
    fetch_single(20'h00000, 0);

    repeat (3) tick();
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("ins_queue_empty", 32'(exp_ins_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
